hc85_seq_cmp: RTL and testbench

//  Sequential, parametrised successor to the 4-bit HC85 magnitude comparator.

---
 rtl/hc85_seq_cmp.sv | 122 ++++++++++++
 tb/tb_hc85_seq_cmp.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hc85_seq_cmp.sv
// hc85_seq_cmp: sequential HC85-style magnitude comparator.
// Walks the operands SLICE bits per clock, MSB slice first.
module hc85_seq_cmp #(
  parameter int WIDTH      = 16,
  parameter int SLICE      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SMODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             IAGB,
  input  logic             IASB,
  input  logic             IAEB,
  output logic             BUSY,
  output logic             DONE,
  output logic             QAGB,
  output logic             QASB,
  output logic             QAEB
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]                   state;
  logic [IW-1:0]                idx;
  logic [NSLICE-1:0][SLICE-1:0] a_q;
  logic [NSLICE-1:0][SLICE-1:0] b_q;
  logic                         c_gt;
  logic                         c_lt;
  logic                         c_eq;
  logic                         hit;
  logic                         p_gt;
  logic                         p_lt;

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic             gt;
  logic             lt;
  logic             ne;
  logic             fin;
  logic [2:0]       res;

  always_comb begin
    sl_a = a_q[idx];
    sl_b = b_q[idx];
    gt   = sl_a > sl_b;
    lt   = sl_a < sl_b;
    ne   = gt | lt;
    fin  = (idx == '0) || (EARLY_EXIT && ne);
    // first differing slice wins; cascade only when all slices match
    if (hit) begin
      res = {p_gt, p_lt, 1'b0};
    end else if (ne) begin
      res = {gt, lt, 1'b0};
    end else begin
      res = {~c_eq & ~c_lt, ~c_eq & ~c_gt, c_eq};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      idx   <= LAST;
      a_q   <= '0;
      b_q   <= '0;
      c_gt  <= 1'b0;
      c_lt  <= 1'b0;
      c_eq  <= 1'b0;
      hit   <= 1'b0;
      p_gt  <= 1'b0;
      p_lt  <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      QAGB  <= 1'b0;
      QASB  <= 1'b0;
      QAEB  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            state <= S_RUN;
            BUSY  <= 1'b1;
            idx   <= LAST;
            a_q   <= A ^ ({WIDTH{SMODE}} & MSB);
            b_q   <= B ^ ({WIDTH{SMODE}} & MSB);
            c_gt  <= IAGB;
            c_lt  <= IASB;
            c_eq  <= IAEB;
            hit   <= 1'b0;
          end
        end
        default: begin
          if (ne && !hit) begin
            hit  <= 1'b1;
            p_gt <= gt;
            p_lt <= lt;
          end
          if (fin) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            QAGB  <= res[2];
            QASB  <= res[1];
            QAEB  <= res[0];
          end else begin
            idx <= idx - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hc85_seq_cmp.sv
// tb_hc85_seq_cmp: vector table plus hand sequences for hc85_seq_cmp.
// Two instances: early exit on (u0) and off (u1).
module tb_hc85_seq_cmp;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0;
  logic        start1;
  logic        smode;
  logic [15:0] a;
  logic [15:0] b;
  logic        iagb;
  logic        iasb;
  logic        iaeb;
  logic        busy0, done0, gt0, lt0, eq0;
  logic        busy1, done1, gt1, lt1, eq1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hc85_seq_cmp #(.WIDTH(16), .SLICE(4), .EARLY_EXIT(1'b1)) u0 (
    .CLK(clk), .RST(rst), .START(start0), .SMODE(smode),
    .A(a), .B(b), .IAGB(iagb), .IASB(iasb), .IAEB(iaeb),
    .BUSY(busy0), .DONE(done0),
    .QAGB(gt0), .QASB(lt0), .QAEB(eq0)
  );

  hc85_seq_cmp #(.WIDTH(16), .SLICE(4), .EARLY_EXIT(1'b0)) u1 (
    .CLK(clk), .RST(rst), .START(start1), .SMODE(smode),
    .A(a), .B(b), .IAGB(iagb), .IASB(iasb), .IAEB(iaeb),
    .BUSY(busy1), .DONE(done1),
    .QAGB(gt1), .QASB(lt1), .QAEB(eq1)
  );

  // casc = {iaeb, iagb, iasb}; q = {gt, lt, eq}
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [2:0]  casc;
    logic [2:0]  q;
    int          lat;
  } vec_t;

  typedef struct {
    logic [2:0] q;
    int         lat;
  } exp_t;

  vec_t vecs[11];
  exp_t sb0[$];
  exp_t sb1[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no DONE within cycle budget", name);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    bit   got0;
    bit   got1;
    got0 = 1'b0;
    got1 = 1'b0;
    @(negedge clk);
    a      = v.a;
    b      = v.b;
    smode  = v.sm;
    {iaeb, iagb, iasb} = v.casc;
    start0 = 1'b1;
    start1 = 1'b1;
    sb0.push_back('{q: v.q, lat: v.lat});
    sb1.push_back('{q: v.q, lat: 4});
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    chk("busy0_accept", 32'(busy0), 32'd1);
    chk("busy1_accept", 32'(busy1), 32'd1);
    for (int k = 1; k <= 10 && !(got0 && got1); k++) begin
      @(negedge clk);
      if (!got0 && done0) begin
        e = sb0.pop_front();
        chk("q_ee1", 32'({gt0, lt0, eq0}), 32'(e.q));
        chk("lat_ee1", 32'(k), 32'(e.lat));
        got0 = 1'b1;
      end
      if (!got1 && done1) begin
        e = sb1.pop_front();
        chk("q_ee0", 32'({gt1, lt1, eq1}), 32'(e.q));
        chk("lat_ee0", 32'(k), 32'(e.lat));
        got1 = 1'b1;
      end
    end
    if (!got0) begin
      timeout("done_ee1");
      void'(sb0.pop_front());
    end
    if (!got1) begin
      timeout("done_ee0");
      void'(sb1.pop_front());
    end
  endtask

  initial begin
    int   k;
    int   ndone;
    bit   got;
    vecs[0]  = '{16'h1234, 16'h1235, 1'b0, 3'b000, 3'b010, 4};
    vecs[1]  = '{16'h9000, 16'h1000, 1'b0, 3'b000, 3'b100, 1};
    vecs[2]  = '{16'h9000, 16'h1000, 1'b1, 3'b000, 3'b010, 1};
    vecs[3]  = '{16'hBEEF, 16'hBEEF, 1'b0, 3'b100, 3'b001, 4};
    vecs[4]  = '{16'hBEEF, 16'hBEEF, 1'b0, 3'b010, 3'b100, 4};
    vecs[5]  = '{16'hBEEF, 16'hBEEF, 1'b0, 3'b001, 3'b010, 4};
    vecs[6]  = '{16'hBEEF, 16'hBEEF, 1'b0, 3'b011, 3'b000, 4};
    vecs[7]  = '{16'hBEEF, 16'hBEEF, 1'b0, 3'b000, 3'b110, 4};
    vecs[8]  = '{16'h00F0, 16'h00E0, 1'b0, 3'b000, 3'b100, 3};
    vecs[9]  = '{16'h8000, 16'h7FFF, 1'b1, 3'b000, 3'b010, 1};
    vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 3'b100, 3'b001, 4};

    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    smode  = 1'b0;
    a      = '0;
    b      = '0;
    {iaeb, iagb, iasb} = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_u0", 32'({busy0, done0, gt0, lt0, eq0}), 32'd0);
    chk("reset_u1", 32'({busy1, done1, gt1, lt1, eq1}), 32'd0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);
    run_vec('{16'hF000, 16'h0000, 1'b0, 3'b000, 3'b100, 1});

    // START held through BUSY, then accepted in the DONE cycle
    @(negedge clk);
    a = 16'h1234;
    b = 16'h1235;
    smode = 1'b0;
    {iaeb, iagb, iasb} = 3'b000;
    start0 = 1'b1;
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'h0000;
    chk("hold_busy", 32'(busy0), 32'd1);
    got = 1'b0;
    k = 0;
    while (!got && k < 10) begin
      @(negedge clk);
      k++;
      got = done0;
    end
    if (!got) begin
      timeout("hold_done");
    end else begin
      chk("hold_lat", 32'(k), 32'd4);
      chk("hold_q", 32'({gt0, lt0, eq0}), 32'b010);
    end
    @(negedge clk);
    start0 = 1'b0;
    chk("b2b_busy", 32'(busy0), 32'd1);
    chk("b2b_qhold", 32'({gt0, lt0, eq0}), 32'b010);
    @(negedge clk);
    chk("b2b_done", 32'(done0), 32'd1);
    chk("b2b_q", 32'({gt0, lt0, eq0}), 32'b100);

    // reset on the second RUN edge aborts silently
    @(negedge clk);
    a = 16'h0001;
    b = 16'h0002;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_u0", 32'({busy0, done0, gt0, lt0, eq0}), 32'd0);
    chk("abort_u1", 32'({busy1, done1, gt1, lt1, eq1}), 32'd0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    chk("abort_nodone", 32'(ndone), 32'd0);

    // RST and START together: reset wins
    a = 16'h1000;
    b = 16'h2000;
    rst = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start0 = 1'b0;
    chk("rst_wins", 32'(busy0), 32'd0);
    @(negedge clk);
    chk("rst_wins_idle", 32'({busy0, done0}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
